// File: rtl/pipeline_control_pkg.sv
// pipeline_control_pkg: shared FSM states, stall encodings, stage indices and reset polarity.
package pipeline_control_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, MULTI = 2'd1, FLUSH = 2'd2} state_e;
  localparam logic [5:0] STALL_EXC   = 6'b111111;
  localparam logic [5:0] STALL_MEM   = 6'b011111;
  localparam logic [5:0] STALL_MULTI = 6'b001111;
  localparam logic [5:0] STALL_ID    = 6'b000111;
  localparam logic [5:0] STALL_IF    = 6'b000011;
  localparam logic [5:0] STALL_NONE  = 6'b000000;
  localparam int STG_PC    = 0;
  localparam int STG_IF_ID = 1;
  localparam int STG_ID_EX = 2;
  localparam int STG_EX_MEM = 3;
  localparam int STG_MEM_WB = 4;
  localparam int STG_WB    = 5;
  localparam logic RST_ACTIVE = 1'b0;
endpackage

// File: rtl/pipeline_stall_encoder.sv
// pipeline_stall_encoder: maps prioritized hazard requests onto the per-stage freeze vector.
module pipeline_stall_encoder
  import pipeline_control_pkg::*;
(
  input  logic       req_exc,
  input  logic       req_mem,
  input  logic       req_multi,
  input  logic       req_id,
  input  logic       req_if,
  output logic [5:0] stall
);
  always_comb begin
    stall = req_exc   ? STALL_EXC   :
            req_mem   ? STALL_MEM   :
            req_multi ? STALL_MULTI :
            req_id    ? STALL_ID    :
            req_if    ? STALL_IF    : STALL_NONE;
  end
endmodule

// File: rtl/pipeline_control.sv
// pipeline_control: hazard/stall FSM with multi-cycle EX tracking, exception flush and stall counting.
module pipeline_control
  import pipeline_control_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_request_if,
  input  logic        stall_request_id,
  input  logic        stall_request_mem,
  input  logic        multicycle_start,
  input  logic [5:0]  multicycle_length,
  input  logic        exception_valid,
  input  logic [31:0] exception_vector,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        multicycle_done,
  output logic [31:0] stall_cycles
);
  state_e      state_q, state_d;
  logic [5:0]  remaining_q, remaining_d;
  logic        flush_q, flush_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic        done_q, done_d;
  logic [31:0] cycles_q, cycles_d;
  logic        active, in_multi, exc, start_ok, start_long, finish, multi_busy;
  logic [5:0]  enc_stall;
  always_comb begin
    in_multi   = state_q == MULTI;
    active     = (state_q == RUN) || in_multi;
    exc        = active && exception_valid;
    start_ok   = state_q == RUN && multicycle_start && !exception_valid && !stall_request_mem;
    start_long = multicycle_length > 6'd1;
    // The final MULTI cycle releases EX so its result can advance.
    multi_busy = (in_multi && remaining_q > 6'd1) || (start_ok && start_long);
    finish     = in_multi && !exception_valid && !stall_request_mem && remaining_q == 6'd1;
  end
  pipeline_stall_encoder u_enc (
    .req_exc  (exc),
    .req_mem  (active && stall_request_mem),
    .req_multi(multi_busy),
    .req_id   (active && stall_request_id),
    .req_if   (active && stall_request_if),
    .stall    (enc_stall)
  );
  always_comb begin
    stall       = (reset == RST_ACTIVE) ? STALL_NONE : enc_stall;
    state_d     = exc ? FLUSH :
                  (start_ok && start_long) ? MULTI :
                  (finish || state_q == FLUSH) ? RUN : state_q;
    remaining_d = exc ? 6'd0 :
                  (start_ok && start_long) ? multicycle_length - 6'd1 :
                  (in_multi && !stall_request_mem) ? remaining_q - 6'd1 : remaining_q;
    flush_d     = exc;
    new_pc_d    = exc ? exception_vector : new_pc_q;
    done_d      = finish || (start_ok && !start_long);
    cycles_d    = cycles_q + {31'd0, stall != STALL_NONE};
  end
  always_ff @(posedge clock or negedge reset) begin
    if (reset == RST_ACTIVE) begin
      state_q     <= RUN;
      remaining_q <= 6'd0;
      flush_q     <= 1'b0;
      new_pc_q    <= 32'd0;
      done_q      <= 1'b0;
      cycles_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      flush_q     <= flush_d;
      new_pc_q    <= new_pc_d;
      done_q      <= done_d;
      cycles_q    <= cycles_d;
    end
  end
  assign flush           = flush_q;
  assign new_pc          = new_pc_q;
  assign multicycle_done = done_q;
  assign stall_cycles    = cycles_q;
endmodule

// File: tb/tb_pipeline_control.sv
// tb_pipeline_control: directed scenarios plus randomized traffic against a cycle-count reference model.
module tb_pipeline_control;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        s_if = 1'b0, s_id = 1'b0, s_mem = 1'b0, mc_start = 1'b0, exc_v = 1'b0;
  logic [5:0]  mc_len = 6'd0;
  logic [31:0] exc_vec = 32'd0;
  logic [5:0]  stall;
  logic        flush, mc_done;
  logic [31:0] new_pc, stall_cycles;
  int n_cmp = 0, n_fail = 0;
  int          m_left;
  bit          m_flush, m_done;
  logic [31:0] m_npc, m_cnt;

  pipeline_control dut (
    .clock(clock), .reset(reset),
    .stall_request_if(s_if), .stall_request_id(s_id), .stall_request_mem(s_mem),
    .multicycle_start(mc_start), .multicycle_length(mc_len),
    .exception_valid(exc_v), .exception_vector(exc_vec),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .multicycle_done(mc_done), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  task automatic m_reset();
    m_left = 0; m_flush = 0; m_done = 0; m_npc = 0; m_cnt = 0;
  endtask

  // m_left counts the MULTI cycles still owed; the last one no longer stalls.
  function automatic logic [5:0] exp_stall();
    if (reset == 1'b0 || m_flush) return 6'b000000;
    if (exc_v) return 6'b111111;
    if (s_mem) return 6'b011111;
    if (m_left > 1 || (m_left == 0 && mc_start && mc_len >= 2)) return 6'b001111;
    if (s_id) return 6'b000111;
    if (s_if) return 6'b000011;
    return 6'b000000;
  endfunction

  task automatic drive(input bit i_if, i_id, i_mem, i_st, input logic [5:0] len,
                       input bit ex, input logic [31:0] v);
    s_if = i_if; s_id = i_id; s_mem = i_mem; mc_start = i_st; mc_len = len;
    exc_v = ex; exc_vec = v;
    #2;
  endtask

  task automatic tick();
    logic [5:0] e;
    e = exp_stall();
    @(posedge clock);
    if (m_flush) begin
      m_flush = 0; m_done = 0;
    end else if (exc_v) begin
      m_flush = 1; m_npc = exc_vec; m_left = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        if (!s_mem) begin
          if (m_left == 1) m_done = 1;
          m_left--;
        end
      end else if (mc_start && !s_mem) begin
        if (mc_len >= 2) m_left = int'(mc_len) - 1;
        else m_done = 1;
      end
    end
    if (e != 0) m_cnt++;
    #1;
  endtask

  task automatic test_reset();
    m_reset();
    #2;
    n_cmp++; if (stall !== 6'b000000) begin n_fail++; $display("FAIL reset_stall got=%b want=000000", stall); end
    n_cmp++; if (flush !== 1'b0 || mc_done !== 1'b0) begin n_fail++; $display("FAIL reset_flags flush=%b done=%b want 0/0", flush, mc_done); end
    n_cmp++; if (new_pc !== 32'd0 || stall_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_regs new_pc=%h cycles=%0d want 0/0", new_pc, stall_cycles); end
    drive(0, 1, 0, 0, 0, 0, 0);
    @(posedge clock); #1;
    n_cmp++; if (stall !== 6'b000000 || stall_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_held stall=%b cycles=%0d want 000000/0", stall, stall_cycles); end
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_id_stall();
    logic [31:0] base;
    base = m_cnt;
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 0, 0, 0, 0);
      n_cmp++; if (stall !== 6'b000111) begin n_fail++; $display("FAIL id_stall[%0d] got=%b want=000111", i, stall); end
      tick();
      n_cmp++; if (flush !== 1'b0) begin n_fail++; $display("FAIL id_flush[%0d] got=%b want=0", i, flush); end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (stall_cycles !== base + 2) begin n_fail++; $display("FAIL id_count got=%0d want=%0d", stall_cycles, base + 2); end
  endtask

  task automatic test_multicycle();
    logic [31:0] base;
    base = m_cnt;
    drive(0, 0, 0, 1, 6'd4, 0, 0);
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (stall !== (c < 3 ? 6'b001111 : 6'b000000)) begin n_fail++; $display("FAIL multi_stall[%0d] got=%b want=%b", c, stall, c < 3 ? 6'b001111 : 6'b000000); end
      n_cmp++; if (mc_done !== 1'b0) begin n_fail++; $display("FAIL multi_early_done[%0d] got=%b want=0", c, mc_done); end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
    end
    n_cmp++; if (mc_done !== 1'b1) begin n_fail++; $display("FAIL multi_done got=%b want=1", mc_done); end
    n_cmp++; if (stall_cycles !== base + 3) begin n_fail++; $display("FAIL multi_count got=%0d want=%0d", stall_cycles, base + 3); end
    tick();
    n_cmp++; if (mc_done !== 1'b0) begin n_fail++; $display("FAIL multi_done_pulse got=%b want=0", mc_done); end
  endtask

  task automatic test_multi_mem();
    logic [5:0] want [6] = '{6'b001111, 6'b011111, 6'b001111, 6'b001111, 6'b000000, 6'b000000};
    drive(0, 0, 0, 1, 6'd4, 0, 0);
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (stall !== want[c]) begin n_fail++; $display("FAIL mmem_stall[%0d] got=%b want=%b", c, stall, want[c]); end
      n_cmp++; if (mc_done !== 1'b0) begin n_fail++; $display("FAIL mmem_early_done[%0d] got=%b want=0", c, mc_done); end
      tick();
      drive(0, 0, c == 0, 0, 0, 0, 0);
    end
    n_cmp++; if (mc_done !== 1'b1) begin n_fail++; $display("FAIL mmem_done got=%b want=1", mc_done); end
    tick();
  endtask

  task automatic test_exception();
    drive(0, 0, 0, 1, 6'd8, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 32'h0000_0180);
    n_cmp++; if (stall !== 6'b111111) begin n_fail++; $display("FAIL exc_stall got=%b want=111111", stall); end
    tick();
    n_cmp++; if (flush !== 1'b1 || new_pc !== 32'h0000_0180) begin n_fail++; $display("FAIL exc_flush flush=%b new_pc=%h want 1/00000180", flush, new_pc); end
    drive(1, 1, 1, 1, 6'd5, 1, 32'hdead_beef);
    n_cmp++; if (stall !== 6'b000000) begin n_fail++; $display("FAIL flush_stall got=%b want=000000", stall); end
    tick();
    n_cmp++; if (flush !== 1'b0 || new_pc !== 32'h0000_0180) begin n_fail++; $display("FAIL post_flush flush=%b new_pc=%h want 0/00000180", flush, new_pc); end
    for (int c = 0; c < 8; c++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      n_cmp++; if (stall !== 6'b000000 || mc_done !== 1'b0) begin n_fail++; $display("FAIL exc_abandon[%0d] stall=%b done=%b want 000000/0", c, stall, mc_done); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    drive(0, 0, 0, 1, 6'd10, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    n_cmp++; if (stall !== 6'b000000 || flush !== 1'b0 || mc_done !== 1'b0) begin n_fail++; $display("FAIL areset_out stall=%b flush=%b done=%b want 0", stall, flush, mc_done); end
    n_cmp++; if (stall_cycles !== 32'd0 || new_pc !== 32'd0) begin n_fail++; $display("FAIL areset_regs cycles=%0d new_pc=%h want 0/0", stall_cycles, new_pc); end
    m_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      n_cmp++; if (stall !== 6'b000000 || mc_done !== 1'b0) begin n_fail++; $display("FAIL areset_run[%0d] stall=%b done=%b want 000000/0", c, stall, mc_done); end
      tick();
    end
    n_cmp++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL areset_count got=%0d want=0", stall_cycles); end
  endtask

  task automatic test_if_id_short();
    drive(1, 1, 0, 0, 0, 0, 0);
    n_cmp++; if (stall !== 6'b000111) begin n_fail++; $display("FAIL ifid_stall got=%b want=000111", stall); end
    tick();
    for (int l = 0; l < 2; l++) begin
      drive(0, 0, 0, 1, 6'(l), 0, 0);
      n_cmp++; if (stall !== 6'b000000) begin n_fail++; $display("FAIL short_stall[len%0d] got=%b want=000000", l, stall); end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      n_cmp++; if (mc_done !== 1'b1) begin n_fail++; $display("FAIL short_done[len%0d] got=%b want=1", l, mc_done); end
      tick();
      n_cmp++; if (mc_done !== 1'b0) begin n_fail++; $display("FAIL short_pulse[len%0d] got=%b want=0", l, mc_done); end
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (stall !== 6'b000011) begin n_fail++; $display("FAIL if_stall got=%b want=000011", stall); end
    tick();
  endtask

  task automatic test_random();
    logic [5:0] e;
    bit last;
    for (int c = 0; c < 400; c++) begin
      last = !m_flush && m_left == 1;
      drive(!last && $urandom_range(0, 3) == 0, !last && $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
            6'($urandom_range(0, 7)), $urandom_range(0, 15) == 0, $urandom);
      e = exp_stall();
      n_cmp++; if (stall !== e) begin n_fail++; $display("FAIL rnd_stall[%0d] got=%b want=%b", c, stall, e); end
      tick();
      n_cmp++; if (flush !== m_flush || mc_done !== m_done) begin n_fail++; $display("FAIL rnd_flags[%0d] flush=%b done=%b want %b/%b", c, flush, mc_done, m_flush, m_done); end
      n_cmp++; if (new_pc !== m_npc || stall_cycles !== m_cnt) begin n_fail++; $display("FAIL rnd_regs[%0d] new_pc=%h cycles=%0d want %h/%0d", c, new_pc, stall_cycles, m_npc, m_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_id_stall();
    test_multicycle();
    test_multi_mem();
    test_exception();
    test_async_reset();
    test_if_id_short();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_control.md
PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port stall_request_if  input  1  IF stage cannot deliver an instruction this cycle.
REQ-004 SHALL have port stall_request_id  input  1  ID load-use hazard this cycle.
REQ-005 SHALL have port stall_request_mem  input  1  MEM stage data access not complete this cycle.
REQ-006 SHALL have port multicycle_start  input  1  EX begins a multi-cycle operation (divide/multiply) this cycle.
REQ-007 SHALL have port multicycle_length  input  6  cycle count of that operation, sampled with multicycle_start.
REQ-008 SHALL have port exception_valid  input  1  MEM stage commits an exception this cycle.
REQ-009 SHALL have port exception_vector  input  32  handler PC, sampled with exception_valid.
REQ-010 SHALL have port stall  output  6  freeze per stage: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB.
REQ-011 SHALL have port flush  output  1  clear all pipeline latches to zero.
REQ-012 SHALL have port new_pc  output  32  PC load value, valid while flush=1.
REQ-013 SHALL have port multicycle_done  output  1  one-cycle pulse: EX result may advance.
REQ-014 SHALL have port stall_cycles  output  32  count of cycles with stall!=0, wraps modulo 2^32.

Function
REQ-015 SHALL implement states RUN, MULTI, FLUSH; 6-bit down-counter remaining; registered vector latch.
REQ-016 stall SHALL be combinational from state and inputs; flush, new_pc, multicycle_done SHALL be registered.
REQ-017 Priority in RUN/MULTI: exception_valid > stall_request_mem > MULTI/multicycle_start > stall_request_id > stall_request_if.
REQ-018 Encodings: exception 6'b111111; mem 6'b011111; multicycle 6'b001111; id 6'b000111; if 6'b000011; none 6'b000000.
REQ-019 Stage k stalled with stage k+1 free SHALL imply bubble insertion by the downstream latch; this block emits no separate bubble signal.
REQ-020 RUN, multicycle_start=1, length N>=2, no higher request: stall=001111 this cycle, remaining<=N-1, next state MULTI.
REQ-021 multicycle_start with length 0 or 1 SHALL cause no stall and SHALL pulse multicycle_done next cycle.
REQ-022 MULTI: stall=001111 (or higher-priority encoding); remaining decrements only in cycles with stall_request_mem=0.
REQ-023 MULTI with remaining=1 and stall_request_mem=0: stall=000000 that cycle, multicycle_done=1 next cycle, state RUN.
REQ-024 multicycle_start while in MULTI or FLUSH SHALL be ignored.
REQ-025 exception_valid in RUN or MULTI: stall=111111 that cycle, vector latched, remaining cleared, next state FLUSH.
REQ-026 FLUSH (exactly one cycle): flush=1, new_pc=latched vector, stall=000000, all requests and exception_valid ignored, next state RUN.
REQ-027 new_pc SHALL hold last latched vector when flush=0; consumers ignore it.
REQ-028 stall_cycles SHALL increment by 1 on every rising edge where combinational stall!=0.

Reset
REQ-029 reset=0 SHALL immediately force state RUN, remaining 0, flush 0, new_pc 0, multicycle_done 0, stall_cycles 0, independent of clock.
REQ-030 While reset=0, stall SHALL read 000000; reset during MULTI or FLUSH SHALL abandon the operation without a done pulse.
REQ-031 First rising edge after reset release SHALL evaluate inputs normally in RUN.

Structure
REQ-032 State encodings, the six stall encodings, stage indices and reset polarity SHALL live in the shared defines file.
REQ-033 Priority-to-stall mapping SHALL be one combinational sub-module pipeline_stall_encoder; FSM, counter, registers stay in pipeline_control.

Verification
REQ-034 stall_request_id=1 for 2 cycles in RUN -> stall=000111 both cycles, stall_cycles +2, flush=0.
REQ-035 multicycle_start, length=4, no other requests -> stall=001111 cycles 0-2, 000000 cycle 3, multicycle_done=1 cycle 4, stall_cycles +3.
REQ-036 length=4 with stall_request_mem=1 in cycle 1 -> stall=011111 cycle 1, counter frozen, done one cycle later than REQ-035.
REQ-037 exception_valid, vector 32'h0000_0180, during MULTI -> stall=111111 that cycle; next cycle flush=1, new_pc=32'h0000_0180; no multicycle_done.
REQ-038 reset=0 asserted mid-MULTI between edges -> outputs zero immediately; after release, RUN, stall_cycles=0.
REQ-039 stall_request_if and stall_request_id together -> stall=000111; then length=1 start -> no stall, done pulse next cycle.
